// File: rtl/rnbip_pkg.sv
// rnbip_pkg: shared state encoding and data-memory geometry defaults.
package rnbip_pkg;
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LD_ACC = 2'd1,
    ARB_LD_ACK = 2'd2
  } arb_state_t;
endpackage

// File: rtl/dmem_starve_cnt.sv
// dmem_starve_cnt: saturating count of cycles the loader has waited behind the CPU.
module dmem_starve_cnt #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  logic [7:0] wait_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else if (clr) wait_cnt <= '0;
    else if (inc && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
  assign hit = wait_cnt == 8'(MAX_WAIT);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the MEM stage (fixed priority) and a loader port.
// Define LD_STARVE_GUARD_EN to force a loader access after MAX_WAIT cycles of CPU blocking.
module dmem_arbiter
  import rnbip_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata
);
  arb_state_t state, state_nxt;
  logic force_ld, ld_sel, cpu_ok;
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("MAX_WAIT must be in 1..255");
  end
`ifdef LD_STARVE_GUARD_EN
  logic hit;
  dmem_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (state == ARB_IDLE && ld_req && cpu_req),
    .clr  (state == ARB_IDLE && state_nxt == ARB_LD_ACC),
    .hit  (hit)
  );
  assign force_ld = state == ARB_IDLE && ld_req && hit;
`else
  assign force_ld = 1'b0;
`endif
  always_comb begin
    state_nxt = state == ARB_IDLE   ? ((ld_req && (!cpu_req || force_ld)) ? ARB_LD_ACC : ARB_IDLE)
              : state == ARB_LD_ACC ? ARB_LD_ACK : ARB_IDLE;
    ld_sel    = state == ARB_LD_ACC;
    // CPU strobes are gated by rst_n so a held reset never writes memory
    cpu_ok    = rst_n && cpu_req && !ld_sel && !force_ld;
    mem_addr  = ld_sel ? ld_addr : cpu_addr;
    mem_wdata = ld_sel ? ld_wdata : cpu_wdata;
    mem_wr    = ld_sel ? ld_we : cpu_ok && cpu_we;
    mem_rd    = ld_sel ? !ld_we : cpu_ok && !cpu_we;
    cpu_stall = rst_n && cpu_req && (ld_sel || force_ld);
    ld_ack    = state == ARB_LD_ACK;
    cpu_rdata = mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ARB_IDLE;
      ld_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (ld_sel && !ld_we) ld_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenario tasks with a 256x8 async-read memory model.
module tb_dmem_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_wdata = 0;
  logic [7:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_stall, ld_ack, mem_wr, mem_rd;
  logic [7:0] mem [256];
  int checks = 0, errors = 0;
`ifdef LD_STARVE_GUARD_EN
  localparam int E_ACKS = 1, E_STALLS = 2, E_FIRST_STALL = 15;
`else
  localparam int E_ACKS = 0, E_STALLS = 0, E_FIRST_STALL = -1;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cpu_req = 1; cpu_we = 1; ld_req = 1; ld_we = 1;
    rst_n = 0;
    tick(); tick(); #1;
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b exp 0", mem_wr); end
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL reset_ld_ack: got %b exp 0", ld_ack); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", cpu_stall); end
    checks++; if (ld_rdata !== 8'h00) begin errors++; $display("FAIL reset_ld_rdata: got %h exp 00", ld_rdata); end
    ld_req = 0; ld_we = 0; cpu_req = 0;
    rst_n = 1;
    tick();
  endtask

  task automatic test_cpu;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5; #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall: got %b exp 0", cpu_stall); end
    checks++; if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {2'b10, 8'h10, 8'hA5})
      begin errors++; $display("FAIL cpu_wr_bus: got %b%b %h %h exp 10 10 a5", mem_wr, mem_rd, mem_addr, mem_wdata); end
    tick();
    cpu_we = 0; cpu_wdata = 8'h00; #1;
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL cpu_rd_data: got %h exp a5", cpu_rdata); end
    checks++; if ({cpu_stall, mem_wr, mem_rd} !== 3'b001) begin errors++; $display("FAIL cpu_rd_ctl: got %b exp 001", {cpu_stall, mem_wr, mem_rd}); end
    tick();
    cpu_req = 0;
  endtask

  task automatic test_ld_write;
    ld_req = 1; ld_we = 1; ld_addr = 8'hFF; ld_wdata = 8'h3C; #1;
    checks++; if ({mem_wr, ld_ack} !== 2'b00) begin errors++; $display("FAIL ldw_c1: got %b exp 00", {mem_wr, ld_ack}); end
    tick();
    checks++; if ({mem_wr, ld_ack, mem_addr, mem_wdata} !== {2'b10, 8'hFF, 8'h3C})
      begin errors++; $display("FAIL ldw_c2: got %b%b %h %h exp 10 ff 3c", mem_wr, ld_ack, mem_addr, mem_wdata); end
    tick();
    ld_req = 0; #1;
    checks++; if ({mem_wr, ld_ack} !== 2'b01) begin errors++; $display("FAIL ldw_c3: got %b exp 01", {mem_wr, ld_ack}); end
    checks++; if (mem[8'hFF] !== 8'h3C) begin errors++; $display("FAIL ldw_mem: got %h exp 3c", mem[8'hFF]); end
    tick();
  endtask

  task automatic test_ld_read;
    ld_req = 1; ld_we = 0; ld_addr = 8'hFF; #1;
    tick();
    checks++; if ({mem_wr, mem_rd} !== 2'b01) begin errors++; $display("FAIL ldr_c2: got %b exp 01", {mem_wr, mem_rd}); end
    tick();
    ld_req = 0; #1;
    checks++; if ({ld_ack, ld_rdata} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL ldr_ack: got %b %h exp 1 3c", ld_ack, ld_rdata); end
    tick();
    checks++; if ({ld_ack, ld_rdata} !== {1'b0, 8'h3C}) begin errors++; $display("FAIL ldr_hold: got %b %h exp 0 3c", ld_ack, ld_rdata); end
  endtask

  task automatic test_stall;
    ld_req = 1; ld_we = 1; ld_addr = 8'h20; ld_wdata = 8'h77; #1;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20; #1;
    checks++; if ({cpu_stall, mem_wr, mem_addr} !== {2'b11, 8'h20}) begin errors++; $display("FAIL stall_acc: got %b%b %h exp 11 20", cpu_stall, mem_wr, mem_addr); end
    tick();
    ld_req = 0; #1;
    checks++; if ({cpu_stall, ld_ack, mem_rd} !== 3'b011) begin errors++; $display("FAIL stall_ack: got %b exp 011", {cpu_stall, ld_ack, mem_rd}); end
    checks++; if (cpu_rdata !== 8'h77) begin errors++; $display("FAIL stall_data: got %h exp 77", cpu_rdata); end
    tick();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL stall_after: got %b exp 0", cpu_stall); end
    cpu_req = 0;
    tick();
  endtask

  task automatic test_starve;
    int acks = 0, stalls = 0, first_stall = -1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    ld_req = 1; ld_we = 1; ld_addr = 8'h30; ld_wdata = 8'h11;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (cpu_stall) begin stalls++; if (first_stall < 0) first_stall = c; end
      if (ld_ack) begin acks++; ld_req = 0; end
      tick();
    end
    checks++; if (acks !== E_ACKS) begin errors++; $display("FAIL starve_acks: got %0d exp %0d", acks, E_ACKS); end
    checks++; if (stalls !== E_STALLS) begin errors++; $display("FAIL starve_stalls: got %0d exp %0d", stalls, E_STALLS); end
    checks++; if (first_stall !== E_FIRST_STALL) begin errors++; $display("FAIL starve_first: got %0d exp %0d", first_stall, E_FIRST_STALL); end
    cpu_req = 0; ld_req = 0;
    tick();
  endtask

  task automatic test_rst_mid;
    ld_req = 1; ld_we = 1; ld_addr = 8'h40; ld_wdata = 8'h99; #1;
    tick();
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rstmid_acc: got %b exp 1", mem_wr); end
    rst_n = 0; #1;
    checks++; if ({mem_wr, ld_ack} !== 2'b00) begin errors++; $display("FAIL rstmid_idle: got %b exp 00", {mem_wr, ld_ack}); end
    rst_n = 1; ld_req = 0;
    tick();
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL rstmid_noack: got %b exp 0", ld_ack); end
    ld_req = 1;
    tick(); tick();
    ld_req = 0; #1;
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL rstmid_retry_ack: got %b exp 1", ld_ack); end
    checks++; if (mem[8'h40] !== 8'h99) begin errors++; $display("FAIL rstmid_retry_mem: got %h exp 99", mem[8'h40]); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_cpu();
    test_ld_write();
    test_ld_read();
    test_stall();
    test_starve();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
